// File: rtl/fifo_req_arbiter_if.sv
// rtl/fifo_req_arbiter_if.sv - client-side and AXI_FIFO-side signal bundle for fifo_req_arbiter
interface fifo_req_arbiter_if #(
    parameter int NUM_CLIENTS = 2
);
    logic [32*NUM_CLIENTS-1:0] C_READ_ADDR;
    logic [16*NUM_CLIENTS-1:0] C_READ_COUNT;
    logic [NUM_CLIENTS-1:0]    C_READ_REQ;
    logic [NUM_CLIENTS-1:0]    C_READ_ACK;
    logic [31:0]               C_READ_DATA;
    logic [NUM_CLIENTS-1:0]    C_READ_VALID;
    logic [NUM_CLIENTS-1:0]    C_READ_READY;

    logic [32*NUM_CLIENTS-1:0] C_WRITE_ADDR;
    logic [16*NUM_CLIENTS-1:0] C_WRITE_COUNT;
    logic [NUM_CLIENTS-1:0]    C_WRITE_REQ;
    logic [NUM_CLIENTS-1:0]    C_WRITE_ACK;
    logic [32*NUM_CLIENTS-1:0] C_WRITE_DATA;
    logic [NUM_CLIENTS-1:0]    C_WRITE_VALID;
    logic [NUM_CLIENTS-1:0]    C_WRITE_READY;

    logic [31:0] READ_ADDR;
    logic [15:0] READ_COUNT;
    logic        READ_REQ;
    logic        READ_BUSY;
    logic [31:0] READ_DATA;
    logic        READ_VALID;
    logic        READ_READY;

    logic [31:0] WRITE_ADDR;
    logic [15:0] WRITE_COUNT;
    logic        WRITE_REQ;
    logic        WRITE_BUSY;
    logic [31:0] WRITE_DATA;
    logic        WRITE_VALID;
    logic        WRITE_READY;

    logic        ARB_BUSY;

    modport master (
        input  C_READ_ADDR, C_READ_COUNT, C_READ_REQ, C_READ_READY,
        output C_READ_ACK, C_READ_DATA, C_READ_VALID,
        input  C_WRITE_ADDR, C_WRITE_COUNT, C_WRITE_REQ, C_WRITE_DATA, C_WRITE_VALID,
        output C_WRITE_ACK, C_WRITE_READY,
        output READ_ADDR, READ_COUNT, READ_REQ, READ_READY,
        input  READ_BUSY, READ_DATA, READ_VALID,
        output WRITE_ADDR, WRITE_COUNT, WRITE_REQ, WRITE_DATA, WRITE_VALID,
        input  WRITE_BUSY, WRITE_READY,
        output ARB_BUSY
    );

    modport slave (
        output C_READ_ADDR, C_READ_COUNT, C_READ_REQ, C_READ_READY,
        input  C_READ_ACK, C_READ_DATA, C_READ_VALID,
        output C_WRITE_ADDR, C_WRITE_COUNT, C_WRITE_REQ, C_WRITE_DATA, C_WRITE_VALID,
        input  C_WRITE_ACK, C_WRITE_READY,
        input  READ_ADDR, READ_COUNT, READ_REQ, READ_READY,
        output READ_BUSY, READ_DATA, READ_VALID,
        input  WRITE_ADDR, WRITE_COUNT, WRITE_REQ, WRITE_DATA, WRITE_VALID,
        output WRITE_BUSY, WRITE_READY,
        input  ARB_BUSY
    );
endinterface

// File: rtl/fifo_req_arbiter.sv
// rtl/fifo_req_arbiter.sv - shares one AXI_FIFO port set between clients with tagged read/write arbitration
// Define FIFO_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module fifo_req_arbiter_dir #(
    parameter int N     = 2,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [32*N-1:0] c_addr,
    input  logic [16*N-1:0] c_count,
    input  logic [N-1:0]    c_req,
    output logic [N-1:0]    c_ack,
    output logic [31:0]     m_addr,
    output logic [15:0]     m_count,
    output logic            m_req,
    input  logic            m_busy,
    input  logic            beat,
    output logic [1:0]      own,
    output logic            tag_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_FILL = (AW+1)'(DEPTH);

    logic [1:0]    tag_own_q [DEPTH];
    logic [15:0]   tag_cnt_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   fill_q, fill_d;
    logic [15:0]   rem_q, rem_d;
    logic          rem_ld_q, rem_ld_d;
    logic [N-1:0]  ack_q, ack_d;
    logic [31:0]   addr_q, addr_d;
    logic [15:0]   count_q, count_d;
    logic          req_q, req_d;

    logic [1:0]  win;
    logic        found, grant, push, pop;
    logic [15:0] win_cnt, head_cnt;
    logic [31:0] win_addr;
    int          pick_idx;

`ifndef FIFO_ARB_FIXED_PRIO_EN
    logic [1:0] last_q, last_d;
`endif

    always_comb begin
        win      = '0;
        found    = 1'b0;
        pick_idx = 0;
        for (int k = 0; k < N; k++) begin
`ifdef FIFO_ARB_FIXED_PRIO_EN
            pick_idx = k;
`else
            pick_idx = (int'(last_q) + 1 + k) % N;
`endif
            if (!found && (|(c_req & (N'(1) << pick_idx)))) begin
                found = 1'b1;
                win   = 2'(pick_idx);
            end
        end
    end

    assign win_addr  = 32'(c_addr >> (32 * int'(win)));
    assign win_cnt   = 16'(c_count >> (16 * int'(win)));
    assign tag_empty = (fill_q == '0);
    // Head count comes straight from the tag until its first beat loads rem.
    assign head_cnt  = rem_ld_q ? rem_q : tag_cnt_q[rd_ptr_q];
    assign own       = tag_empty ? 2'd0 : tag_own_q[rd_ptr_q];

    // Any ack pulse blocks arbitration so a still-held REQ is not granted twice.
    assign grant = found & ~(|ack_q) & ~m_busy & (fill_q != FULL_FILL);
    assign push  = grant & (win_cnt != 16'd0);
    assign pop   = beat & ~tag_empty & (head_cnt == 16'd1);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        rem_d    = rem_q;
        rem_ld_d = rem_ld_q;
        ack_d    = '0;
        req_d    = push;
        addr_d   = '0;
        count_d  = '0;
`ifndef FIFO_ARB_FIXED_PRIO_EN
        last_d   = last_q;
`endif
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      fill_d = fill_q + 1'b1;
        else if (pop && !push) fill_d = fill_q - 1'b1;
        if (beat && !tag_empty) begin
            if (pop) begin
                rem_d    = 16'd0;
                rem_ld_d = 1'b0;
            end else begin
                rem_d    = head_cnt - 16'd1;
                rem_ld_d = 1'b1;
            end
        end
        if (grant) begin
            ack_d = N'(1) << win;
`ifndef FIFO_ARB_FIXED_PRIO_EN
            last_d = win;
`endif
        end
        if (push) begin
            addr_d  = win_addr;
            count_d = win_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            rem_q    <= '0;
            rem_ld_q <= 1'b0;
            ack_q    <= '0;
            req_q    <= 1'b0;
            addr_q   <= '0;
            count_q  <= '0;
`ifndef FIFO_ARB_FIXED_PRIO_EN
            last_q   <= 2'(N - 1);
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            rem_q    <= rem_d;
            rem_ld_q <= rem_ld_d;
            ack_q    <= ack_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
`ifndef FIFO_ARB_FIXED_PRIO_EN
            last_q   <= last_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && push) begin
            tag_own_q[wr_ptr_q] <= win;
            tag_cnt_q[wr_ptr_q] <= win_cnt;
        end
    end

    assign c_ack   = ack_q;
    assign m_req   = req_q;
    assign m_addr  = addr_q;
    assign m_count = count_q;
endmodule

module fifo_req_arbiter #(
    parameter int NUM_CLIENTS = 2,
    parameter int TAG_DEPTH   = 4
) (
    input logic                ACLK,
    input logic                ARESETN,
    fifo_req_arbiter_if.master bus
);
    logic [1:0]             rd_own, wr_own;
    logic                   rd_empty, wr_empty;
    logic                   rd_ready, wr_valid, rd_beat, wr_beat;
    logic [NUM_CLIENTS-1:0] rd_oh, wr_oh;

    fifo_req_arbiter_dir #(.N(NUM_CLIENTS), .DEPTH(TAG_DEPTH)) u_rd (
        .clk      (ACLK),
        .resetn   (ARESETN),
        .c_addr   (bus.C_READ_ADDR),
        .c_count  (bus.C_READ_COUNT),
        .c_req    (bus.C_READ_REQ),
        .c_ack    (bus.C_READ_ACK),
        .m_addr   (bus.READ_ADDR),
        .m_count  (bus.READ_COUNT),
        .m_req    (bus.READ_REQ),
        .m_busy   (bus.READ_BUSY),
        .beat     (rd_beat),
        .own      (rd_own),
        .tag_empty(rd_empty)
    );

    fifo_req_arbiter_dir #(.N(NUM_CLIENTS), .DEPTH(TAG_DEPTH)) u_wr (
        .clk      (ACLK),
        .resetn   (ARESETN),
        .c_addr   (bus.C_WRITE_ADDR),
        .c_count  (bus.C_WRITE_COUNT),
        .c_req    (bus.C_WRITE_REQ),
        .c_ack    (bus.C_WRITE_ACK),
        .m_addr   (bus.WRITE_ADDR),
        .m_count  (bus.WRITE_COUNT),
        .m_req    (bus.WRITE_REQ),
        .m_busy   (bus.WRITE_BUSY),
        .beat     (wr_beat),
        .own      (wr_own),
        .tag_empty(wr_empty)
    );

    assign rd_oh    = NUM_CLIENTS'(1) << rd_own;
    assign wr_oh    = NUM_CLIENTS'(1) << wr_own;
    assign rd_ready = ~rd_empty & (|(bus.C_READ_READY & rd_oh));
    assign wr_valid = ~wr_empty & (|(bus.C_WRITE_VALID & wr_oh));
    assign rd_beat  = bus.READ_VALID & rd_ready;
    assign wr_beat  = wr_valid & bus.WRITE_READY;

    assign bus.READ_READY    = rd_ready;
    assign bus.C_READ_DATA   = bus.READ_DATA;
    assign bus.C_READ_VALID  = (bus.READ_VALID & ~rd_empty) ? rd_oh : '0;
    assign bus.WRITE_VALID   = wr_valid;
    assign bus.C_WRITE_READY = (bus.WRITE_READY & ~wr_empty) ? wr_oh : '0;
    assign bus.WRITE_DATA    = 32'(bus.C_WRITE_DATA >> (32 * int'(wr_own)));
    assign bus.ARB_BUSY      = bus.READ_REQ | bus.WRITE_REQ | ~rd_empty | ~wr_empty;
endmodule
